alu_exec: RTL

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec_pkg.sv | 26 ++
 rtl/alu_exec_core.sv | 55 +++++
 rtl/alu_exec.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute unit: opcodes, ROB tag width, queue sizing and result record.
// The optional same-cycle bypass is controlled by the ALU_BYPASS_EN macro in alu_exec.
package alu_exec_pkg;

    localparam int ROBBW = 4;
    localparam int EXQSZ = 4;
    localparam int EXQBW = 2;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    typedef enum logic [5:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
    } op_e;

    typedef struct packed {
        logic [ROBBW-1:0] rob_id;
        logic [31:0]      val;
        logic             jump;
        logic [31:0]      target;
    } res_t;

endpackage

// File: rtl/alu_exec_core.sv
// alu_core: purely combinational compute of {val, jump, target} for one issued operation.
// Unknown opcodes produce an all-zero, non-jumping result.
module alu_core
    import alu_exec_pkg::*;
(
    input  logic [5:0]  code,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    input  logic [31:0] a,
    input  logic [31:0] pc,
    output logic [31:0] val,
    output logic        jump,
    output logic [31:0] target
);

    always_comb begin
        val    = '0;
        jump   = False;
        target = '0;
        case (code)
            OP_ADD:   val = v1 + v2;
            OP_SUB:   val = v1 - v2;
            OP_SLL:   val = v1 << v2[4:0];
            OP_SLT:   val = {31'b0, $signed(v1) < $signed(v2)};
            OP_SLTU:  val = {31'b0, v1 < v2};
            OP_XOR:   val = v1 ^ v2;
            OP_SRL:   val = v1 >> v2[4:0];
            OP_SRA:   val = $signed(v1) >>> v2[4:0];
            OP_OR:    val = v1 | v2;
            OP_AND:   val = v1 & v2;
            OP_ADDI:  val = v1 + a;
            OP_SLTI:  val = {31'b0, $signed(v1) < $signed(a)};
            OP_SLTIU: val = {31'b0, v1 < a};
            OP_XORI:  val = v1 ^ a;
            OP_ORI:   val = v1 | a;
            OP_ANDI:  val = v1 & a;
            OP_SLLI:  val = v1 << a[4:0];
            OP_SRLI:  val = v1 >> a[4:0];
            OP_SRAI:  val = $signed(v1) >>> a[4:0];
            // Branches report only the decision; the link value stays zero.
            OP_BEQ:   begin jump = (v1 == v2);                   target = pc + a; end
            OP_BNE:   begin jump = (v1 != v2);                   target = pc + a; end
            OP_BLT:   begin jump = ($signed(v1) <  $signed(v2)); target = pc + a; end
            OP_BGE:   begin jump = ($signed(v1) >= $signed(v2)); target = pc + a; end
            OP_BLTU:  begin jump = (v1 <  v2);                   target = pc + a; end
            OP_BGEU:  begin jump = (v1 >= v2);                   target = pc + a; end
            OP_LUI:   val = a;
            OP_AUIPC: val = pc + a;
            OP_JAL:   begin val = pc + 32'd4; jump = True; target = pc + a; end
            OP_JALR:  begin val = pc + 32'd4; jump = True; target = (v1 + a) & ~32'd1; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: ALU execute stage with an in-order result FIFO feeding the CDB output registers.
// Define ALU_BYPASS_EN to let a result go straight to the outputs when the queue is empty and the bus is granted.
module alu_exec
    import alu_exec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             jump_wrong,
    input  logic             exe_RS_flag,
    input  logic [31:0]      exe_RS_V1,
    input  logic [31:0]      exe_RS_V2,
    input  logic [31:0]      exe_RS_A,
    input  logic [31:0]      exe_RS_pc,
    input  logic [5:0]       exe_RS_code,
    input  logic [ROBBW-1:0] exe_RS_rob_id,
    input  logic             cdb_grant,
    output logic             ex_nex_ava,
    output logic             ex_cdb_flag,
    output logic [ROBBW-1:0] ex_cdb_rob_id,
    output logic [31:0]      ex_cdb_val,
    output logic             ex_cdb_jump,
    output logic [31:0]      ex_cdb_target,
    output logic             ex_overflow
);

    localparam logic [EXQBW:0]   QSZ     = (EXQBW+1)'(EXQSZ);
    localparam logic [EXQBW:0]   CNT_ONE = (EXQBW+1)'(1);
    localparam logic [EXQBW-1:0] PTR_ONE = EXQBW'(1);

    res_t             q_mem [EXQSZ];
    logic [EXQBW-1:0] head;
    logic [EXQBW-1:0] tail;
    logic [EXQBW:0]   count;

    res_t new_res;
    logic live;
    logic full;
    logic pop;
    logic push;
    logic drop;
    logic bypass;

    alu_core u_core (
        .code   (exe_RS_code),
        .v1     (exe_RS_V1),
        .v2     (exe_RS_V2),
        .a      (exe_RS_A),
        .pc     (exe_RS_pc),
        .val    (new_res.val),
        .jump   (new_res.jump),
        .target (new_res.target)
    );
    assign new_res.rob_id = exe_RS_rob_id;

    // A flush cancels any movement in the same cycle, whatever rdy says.
    assign live = rdy && !jump_wrong;
    assign full = (count == QSZ);
    assign pop  = live && cdb_grant && (count != '0);

`ifdef ALU_BYPASS_EN
    assign bypass = live && exe_RS_flag && cdb_grant && (count == '0);
`else
    assign bypass = False;
`endif

    assign push = live && exe_RS_flag && !bypass && (!full || pop);
    assign drop = live && exe_RS_flag && full && !pop;

    assign ex_nex_ava = (count <= QSZ - 2'd2) || ((count == QSZ - 1'b1) && !exe_RS_flag) || pop;

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[tail] <= new_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ex_cdb_flag   <= False;
            ex_cdb_rob_id <= '0;
            ex_cdb_val    <= '0;
            ex_cdb_jump   <= False;
            ex_cdb_target <= '0;
            ex_overflow   <= False;
        end else if (jump_wrong) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            ex_cdb_flag <= False;
        end else if (rdy) begin
            if (pop) begin
                {ex_cdb_rob_id, ex_cdb_val, ex_cdb_jump, ex_cdb_target} <= q_mem[head];
                head        <= head + PTR_ONE;
                ex_cdb_flag <= True;
            end else if (bypass) begin
                {ex_cdb_rob_id, ex_cdb_val, ex_cdb_jump, ex_cdb_target} <= new_res;
                ex_cdb_flag <= True;
            end else begin
                ex_cdb_flag <= False;
            end
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop) begin
                ex_overflow <= True;
            end
        end
    end

endmodule
